// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg: shared CDB widths, no-lock tag and functional-unit request slots.
`ifndef Reg_Lock_W
`define Reg_Lock_W 6
`endif
`ifndef Data_Width
`define Data_Width 32
`endif
`ifndef Reg_No_Lock
`define Reg_No_Lock 6'h3f
`endif
`ifndef Cdb_Req_Num
`define Cdb_Req_Num 4
`endif
package cdb_arbiter_pkg;
  localparam int Reg_Lock_W = `Reg_Lock_W;
  localparam int Data_Width = `Data_Width;
  localparam int Cdb_Req_Num = `Cdb_Req_Num;
  localparam logic [Reg_Lock_W-1:0] Reg_No_Lock = `Reg_No_Lock;
  typedef enum logic [1:0] {
    SLOT_ALU = 2'd0,
    SLOT_BR  = 2'd1,
    SLOT_LD  = 2'd2,
    SLOT_ST  = 2'd3
  } cdb_slot_e;
endpackage

// File: rtl/cdb_arbiter_rr_pick.sv
// cdb_arbiter_rr_pick: round-robin pick of the first set request at or after ptr.
module cdb_arbiter_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   idx
);
  logic [2*NUM_REQ-1:0] dbl;
  logic [PTR_W-1:0] off;
  logic [PTR_W:0] sum;
  always_comb begin
    dbl = {req, req} >> ptr;
    off = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) off = dbl[i] ? PTR_W'(i) : off;
    sum = {1'b0, ptr} + {1'b0, off};
    idx = sum >= (PTR_W+1)'(NUM_REQ) ? PTR_W'(sum - (PTR_W+1)'(NUM_REQ)) : sum[PTR_W-1:0];
    grant = |req ? NUM_REQ'(1) << idx : '0;
  end
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin common data bus arbiter and broadcast mux.
// Define CDB_OUT_REG_EN to register the broadcast (one-cycle latency).
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_REQ = Cdb_Req_Num,
  parameter int PTR_W = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*Reg_Lock_W-1:0] req_index,
  input  logic [NUM_REQ*Data_Width-1:0] req_result,
  output logic [NUM_REQ-1:0]            grnt,
  output logic                          cdb_valid,
  output logic [Reg_Lock_W-1:0]         cdb_index,
  output logic [Data_Width-1:0]         cdb_result
);
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] pick_idx;
  logic [NUM_REQ-1:0] pick_grant;
  logic bc_valid;
  logic [Reg_Lock_W-1:0] bc_index;
  logic [Data_Width-1:0] bc_result;
  cdb_arbiter_rr_pick #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_pick (
    .req  (req),
    .ptr  (ptr),
    .grant(pick_grant),
    .idx  (pick_idx)
  );
  // Reset masks the grant so no unit frees an entry whose result is never broadcast.
  always_comb begin
    grnt = rst ? '0 : pick_grant;
    bc_valid = |grnt;
    bc_index = bc_valid ? req_index[pick_idx*Reg_Lock_W +: Reg_Lock_W] : Reg_No_Lock;
    bc_result = bc_valid ? req_result[pick_idx*Data_Width +: Data_Width] : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) ptr <= '0;
    else if (|grnt) ptr <= pick_idx == PTR_W'(NUM_REQ - 1) ? '0 : pick_idx + 1'b1;
  end
`ifdef CDB_OUT_REG_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cdb_valid <= 1'b0;
      cdb_index <= Reg_No_Lock;
      cdb_result <= '0;
    end else begin
      cdb_valid <= bc_valid;
      cdb_index <= bc_index;
      cdb_result <= bc_result;
    end
  end
`else
  assign cdb_valid = bc_valid;
  assign cdb_index = bc_index;
  assign cdb_result = bc_result;
`endif
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: vector table plus randomized handshake stream against a round-robin model.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;
`ifdef CDB_OUT_REG_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif
  localparam int N = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] req = '0;
  logic [N*Reg_Lock_W-1:0] req_index;
  logic [N*Data_Width-1:0] req_result;
  logic [N-1:0] grnt;
  logic cdb_valid;
  logic [Reg_Lock_W-1:0] cdb_index;
  logic [Data_Width-1:0] cdb_result;
  logic [Reg_Lock_W-1:0] idx_a [N];
  logic [Data_Width-1:0] res_a [N];
  typedef struct {
    logic r;
    logic [N-1:0] rq;
    logic [N-1:0] g;
  } vec_t;
  typedef struct {
    logic v;
    logic [Reg_Lock_W-1:0] i;
    logic [Data_Width-1:0] d;
  } exp_t;
  vec_t tbl[$];
  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  cdb_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_index (req_index),
    .req_result(req_result),
    .grnt      (grnt),
    .cdb_valid (cdb_valid),
    .cdb_index (cdb_index),
    .cdb_result(cdb_result)
  );
  always #5 clk = ~clk;
  always_comb begin
    req_index = '0;
    req_result = '0;
    for (int k = 0; k < N; k++) begin
      req_index[k*Reg_Lock_W +: Reg_Lock_W] = idx_a[k];
      req_result[k*Data_Width +: Data_Width] = res_a[k];
    end
  end
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", n, a, e, $time);
    end
  endtask
  function automatic logic [N-1:0] model_grant(input logic [N-1:0] rq, input int p);
    logic [N-1:0] g = '0;
    for (int k = N - 1; k >= 0; k--) if (rq[(p + k) % N]) g = '0 | (N'(1) << ((p + k) % N));
    return g;
  endfunction
  task automatic step(input logic r, input logic [N-1:0] rq, input logic [N-1:0] eg);
    exp_t e;
    @(negedge clk);
    rst = r;
    req = rq;
    #1;
    chk("grnt", 64'(grnt), 64'(eg));
    chk("onehot", 64'($onehot0(grnt)), 64'd1);
    e.v = |eg;
    e.i = Reg_No_Lock;
    e.d = '0;
    for (int k = 0; k < N; k++) if (eg[k]) begin
      e.i = idx_a[k];
      e.d = res_a[k];
    end
    sb.push_back(e);
    if (sb.size() > LAT) begin
      e = sb.pop_front();
      chk("cdb_valid", 64'(cdb_valid), 64'(e.v));
      chk("cdb_index", 64'(cdb_index), 64'(e.i));
      chk("cdb_result", 64'(cdb_result), 64'(e.d));
    end
  endtask
  initial begin
    logic [N-1:0] pend;
    logic [N-1:0] g;
    int mptr;
    int wait_c [N];
    for (int k = 0; k < N; k++) idx_a[k] = Reg_Lock_W'(4 + k);
    res_a[0] = 32'hdead0000;
    res_a[1] = 32'h00001234;
    res_a[2] = 32'h000055aa;
    res_a[3] = 32'hcafe0003;
    tbl = '{
      '{1'b1, 4'hf, 4'h0}, '{1'b1, 4'hf, 4'h0},
      '{1'b0, 4'h2, 4'h2}, '{1'b0, 4'h0, 4'h0}, '{1'b0, 4'h8, 4'h8},
      '{1'b0, 4'hf, 4'h1}, '{1'b0, 4'hf, 4'h2}, '{1'b0, 4'hf, 4'h4},
      '{1'b0, 4'hf, 4'h8}, '{1'b0, 4'hf, 4'h1}, '{1'b0, 4'hf, 4'h2},
      '{1'b0, 4'h4, 4'h4}, '{1'b0, 4'h9, 4'h8}, '{1'b0, 4'h9, 4'h1},
      '{1'b0, 4'h9, 4'h8},
      '{1'b0, 4'hf, 4'h1}, '{1'b0, 4'hf, 4'h2}, '{1'b1, 4'hf, 4'h0},
      '{1'b0, 4'hf, 4'h1},
      '{1'b0, 4'h0, 4'h0}, '{1'b0, 4'h6, 4'h2}, '{1'b0, 4'h0, 4'h0}
    };
    foreach (tbl[t]) step(tbl[t].r, tbl[t].rq, tbl[t].g);
    mptr = 2;
    pend = '0;
    for (int k = 0; k < N; k++) wait_c[k] = 0;
    for (int c = 0; c < 80; c++) begin
      pend = pend | N'($urandom_range(0, 15));
      for (int k = 0; k < N; k++) begin
        idx_a[k] = Reg_Lock_W'($urandom_range(0, 62));
        res_a[k] = $urandom;
      end
      g = model_grant(pend, mptr);
      step(1'b0, pend, g);
      for (int k = 0; k < N; k++) begin
        if (g[k]) begin
          chk("fair_wait", 64'(wait_c[k] > N - 1), 64'd0);
          wait_c[k] = 0;
          mptr = (k + 1) % N;
        end else if (pend[k]) wait_c[k]++;
      end
      pend = pend & ~g;
    end
    step(1'b0, 4'h0, 4'h0);
    step(1'b0, 4'h0, 4'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
